uart_packet_parser: RTL and testbench

//   Consumes the byte stream from the UART receiver (byte + 1-cycle valid strobe).

---
 rtl/uart_packet_parser.sv | 147 ++++++++++++++
 tb/tb_uart_packet_parser.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_packet_parser.sv
// ---------------------------------------------------------------------------
// uart_packet_parser
// Assembles 5-byte command frames (SYNC, CMD, D_HI, D_LO, CHK) from a UART
// receiver byte stream. Each good frame is delivered as a single valid pulse
// with its {command, data} pair. The parser also flags checksum mismatches
// and frames abandoned on an inter-byte timeout.
// ---------------------------------------------------------------------------
module uart_packet_parser #(
   parameter int         CLKS_PER_BIT = 5208,
   parameter logic [7:0] SYNC_BYTE    = 8'hAA,
   parameter int         TIMEOUT_CLKS = CLKS_PER_BIT * 20
) (
   input  logic        i_Clock,
   input  logic        i_Rst_n,
   input  logic        i_Rx_DV,
   input  logic [7:0]  i_Rx_Byte,
   output logic        o_Pkt_Valid,
   output logic [7:0]  o_Pkt_Cmd,
   output logic [15:0] o_Pkt_Data,
   output logic        o_Pkt_Err,
   output logic        o_Timeout,
   output logic        o_Busy
);

   // One spare bit above what TIMEOUT_CLKS needs, so the counter saturates
   // instead of wrapping.
   localparam int              CNT_W    = $clog2(TIMEOUT_CLKS) + 1;
   localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CLKS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CMD  = 3'd1,
      S_DHI  = 3'd2,
      S_DLO  = 3'd3,
      S_CHK  = 3'd4
   } t_state;

   t_state            r_State;
   logic [CNT_W-1:0]  r_Cnt;
   logic [7:0]        r_Cmd_Byte;
   logic [7:0]        r_Dhi_Byte;
   logic [7:0]        r_Dlo_Byte;
   logic              r_Pkt_Valid;
   logic              r_Pkt_Err;
   logic              r_Timeout;
   logic [7:0]        r_Pkt_Cmd;
   logic [15:0]       r_Pkt_Data;

   logic [7:0]        w_Chk_Expected;
   logic              w_In_Frame;
   logic              w_Terminal;

   // Checksum of the stored payload and frame/timeout qualifiers
   always_comb begin
      w_Chk_Expected = r_Cmd_Byte ^ r_Dhi_Byte ^ r_Dlo_Byte;
      w_In_Frame     = (r_State == S_CMD) || (r_State == S_DHI) ||
                       (r_State == S_DLO) || (r_State == S_CHK);
      w_Terminal     = (r_Cnt == TERM_CNT);
   end

   // Frame FSM with inter-byte timeout; all outputs except busy are registered
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_State     <= S_IDLE;
         r_Cnt       <= '0;
         r_Cmd_Byte  <= 8'h00;
         r_Dhi_Byte  <= 8'h00;
         r_Dlo_Byte  <= 8'h00;
         r_Pkt_Valid <= 1'b0;
         r_Pkt_Err   <= 1'b0;
         r_Timeout   <= 1'b0;
         r_Pkt_Cmd   <= 8'h00;
         r_Pkt_Data  <= 16'h0000;
      end else begin
         // Pulses last exactly one cycle
         r_Pkt_Valid <= 1'b0;
         r_Pkt_Err   <= 1'b0;
         r_Timeout   <= 1'b0;

         if (w_In_Frame && !i_Rx_DV && w_Terminal) begin
            // Line went quiet mid-frame: abandon it. A byte arriving on the
            // terminal cycle takes the normal path below instead.
            r_Timeout <= 1'b1;
            r_State   <= S_IDLE;
            r_Cnt     <= '0;
         end else begin
            // Gap counter: cleared by every byte, frozen at zero when idle
            if (!w_In_Frame || i_Rx_DV) begin
               r_Cnt <= '0;
            end else if (r_Cnt != CNT_MAX) begin
               r_Cnt <= r_Cnt + 1'b1;
            end

            case (r_State)
               S_IDLE: begin
                  if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
                     r_State <= S_CMD;
                  end
               end
               S_CMD: begin
                  if (i_Rx_DV) begin
                     r_Cmd_Byte <= i_Rx_Byte;
                     r_State    <= S_DHI;
                  end
               end
               S_DHI: begin
                  if (i_Rx_DV) begin
                     r_Dhi_Byte <= i_Rx_Byte;
                     r_State    <= S_DLO;
                  end
               end
               S_DLO: begin
                  if (i_Rx_DV) begin
                     r_Dlo_Byte <= i_Rx_Byte;
                     r_State    <= S_CHK;
                  end
               end
               S_CHK: begin
                  if (i_Rx_DV) begin
                     if (i_Rx_Byte == w_Chk_Expected) begin
                        r_Pkt_Valid <= 1'b1;
                        r_Pkt_Cmd   <= r_Cmd_Byte;
                        r_Pkt_Data  <= {r_Dhi_Byte, r_Dlo_Byte};
                     end else begin
                        r_Pkt_Err   <= 1'b1;
                     end
                     r_State <= S_IDLE;
                  end
               end
               default: begin
                  // Illegal encoding: recover to idle
                  r_State <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign o_Pkt_Valid = r_Pkt_Valid;
   assign o_Pkt_Err   = r_Pkt_Err;
   assign o_Timeout   = r_Timeout;
   assign o_Pkt_Cmd   = r_Pkt_Cmd;
   assign o_Pkt_Data  = r_Pkt_Data;
   assign o_Busy      = (r_State != S_IDLE);

endmodule

// File: tb/tb_uart_packet_parser.sv
// ---------------------------------------------------------------------------
// tb_uart_packet_parser
// Directed frames plus randomized byte streams, checked every cycle against a
// queue-based frame model, with literal expectations pinning key results.
// ---------------------------------------------------------------------------
module tb_uart_packet_parser;

   localparam int TO = 40;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_dv = 1'b0;
   logic [7:0]  rx_byte = 8'h00;
   logic        pkt_valid;
   logic [7:0]  pkt_cmd;
   logic [15:0] pkt_data;
   logic        pkt_err;
   logic        timeout;
   logic        busy;

   int n_cmp = 0;
   int n_mis = 0;
   int n_dut_valid = 0;
   int n_dut_to = 0;

   uart_packet_parser #(
      .CLKS_PER_BIT(2),
      .SYNC_BYTE   (8'hAA),
      .TIMEOUT_CLKS(TO)
   ) dut (
      .i_Clock    (clk),
      .i_Rst_n    (rst_n),
      .i_Rx_DV    (rx_dv),
      .i_Rx_Byte  (rx_byte),
      .o_Pkt_Valid(pkt_valid),
      .o_Pkt_Cmd  (pkt_cmd),
      .o_Pkt_Data (pkt_data),
      .o_Pkt_Err  (pkt_err),
      .o_Timeout  (timeout),
      .o_Busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0]  fq[$];
   int          gap = 0;
   logic        exp_valid = 1'b0;
   logic        exp_err = 1'b0;
   logic        exp_to = 1'b0;
   logic [7:0]  exp_cmd = 8'h00;
   logic [15:0] exp_data = 16'h0000;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fq.delete();
         gap = 0;
         exp_valid = 1'b0;
         exp_err = 1'b0;
         exp_to = 1'b0;
         exp_cmd = 8'h00;
         exp_data = 16'h0000;
      end else begin
         exp_valid = 1'b0;
         exp_err = 1'b0;
         exp_to = 1'b0;
         if (fq.size() == 0) begin
            if (rx_dv && rx_byte == 8'hAA) begin
               fq.push_back(rx_byte);
               gap = 0;
            end
         end else if (rx_dv) begin
            fq.push_back(rx_byte);
            gap = 0;
            if (fq.size() == 5) begin
               if ((fq[1] ^ fq[2] ^ fq[3]) == fq[4]) begin
                  exp_valid = 1'b1;
                  exp_cmd = fq[1];
                  exp_data = {fq[2], fq[3]};
               end else begin
                  exp_err = 1'b1;
               end
               fq.delete();
            end
         end else begin
            gap++;
            if (gap >= TO) begin
               exp_to = 1'b1;
               fq.delete();
               gap = 0;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(posedge clk) begin
      #1;
      check("valid", 32'(pkt_valid), 32'(exp_valid));
      check("err",   32'(pkt_err),   32'(exp_err));
      check("tmo",   32'(timeout),   32'(exp_to));
      check("cmd",   32'(pkt_cmd),   32'(exp_cmd));
      check("data",  32'(pkt_data),  32'(exp_data));
      check("busy",  32'(busy),      32'(fq.size() != 0));
      if (pkt_valid) n_dut_valid++;
      if (timeout)   n_dut_to++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive_byte(input logic [7:0] b);
      @(negedge clk);
      rx_dv = 1'b1;
      rx_byte = b;
      @(negedge clk);
      rx_dv = 1'b0;
      rx_byte = 8'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [7:0] hi,
                             input logic [7:0] lo, input logic [7:0] chk);
      drive_byte(8'hAA);
      drive_byte(c);
      drive_byte(hi);
      drive_byte(lo);
      drive_byte(chk);
   endtask

   function automatic int pick_gap();
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 7)      return int'($urandom_range(0, 3));
      else if (r < 9) return int'($urandom_range(TO - 4, TO));
      else            return int'($urandom_range(0, TO + 2));
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int v0;
      logic [7:0] c, hi, lo, ck, b;
      int kind, nb;

      // Reset state
      idle(3);
      check("rst_valid", 32'(pkt_valid), 32'd0);
      check("rst_busy",  32'(busy),      32'd0);
      check("rst_cmd",   32'(pkt_cmd),   32'd0);
      check("rst_data",  32'(pkt_data),  32'd0);
      rst_n = 1'b1;
      idle(2);

      // 1. Good frame
      send_frame(8'h12, 8'h34, 8'h56, 8'h70);
      $display("T1 good frame AA 12 34 56 70");
      check("t1_valid", 32'(pkt_valid), 32'd1);
      check("t1_err",   32'(pkt_err),   32'd0);
      check("t1_cmd",   32'(pkt_cmd),   32'h12);
      check("t1_data",  32'(pkt_data),  32'h3456);
      check("t1_model_cmd", 32'(exp_cmd), 32'h12);
      idle(2);

      // 2. Bad checksum
      send_frame(8'h12, 8'h34, 8'h56, 8'h71);
      $display("T2 bad checksum AA 12 34 56 71");
      check("t2_err",   32'(pkt_err),   32'd1);
      check("t2_valid", 32'(pkt_valid), 32'd0);
      check("t2_cmd",   32'(pkt_cmd),   32'h12);
      check("t2_data",  32'(pkt_data),  32'h3456);
      idle(1);
      check("t2_busy",  32'(busy),      32'd0);

      // 3. Junk, then a frame
      drive_byte(8'h00); check("t3_busy0", 32'(busy), 32'd0);
      drive_byte(8'hFF); check("t3_busy1", 32'(busy), 32'd0);
      drive_byte(8'h55); check("t3_busy2", 32'(busy), 32'd0);
      send_frame(8'h01, 8'h00, 8'h02, 8'h03);
      $display("T3 junk 00 FF 55 then AA 01 00 02 03");
      check("t3_valid", 32'(pkt_valid), 32'd1);
      check("t3_cmd",   32'(pkt_cmd),   32'h01);
      check("t3_data",  32'(pkt_data),  32'h0002);
      idle(2);

      // 4. Timeout after AA,12, then a frame carrying SYNC as data
      v0 = n_dut_to;
      drive_byte(8'hAA);
      drive_byte(8'h12);
      idle(TO - 1);
      check("t4_no_tmo_yet", 32'(timeout), 32'd0);
      check("t4_busy_yet",   32'(busy),    32'd1);
      idle(1);
      $display("T4 timeout after AA 12");
      check("t4_tmo",  32'(timeout), 32'd1);
      check("t4_busy", 32'(busy),    32'd0);
      check("t4_count", 32'(n_dut_to - v0), 32'd1);
      send_frame(8'h05, 8'hAA, 8'h00, 8'hAF);
      $display("T4 frame AA 05 AA 00 AF");
      check("t4_valid", 32'(pkt_valid), 32'd1);
      check("t4_cmd",   32'(pkt_cmd),   32'h05);
      check("t4_data",  32'(pkt_data),  32'hAA00);
      idle(2);

      // 5. DV on terminal-count cycle wins
      v0 = n_dut_to;
      drive_byte(8'hAA);
      drive_byte(8'h12);
      idle(TO - 2);
      drive_byte(8'h34);
      check("t5_no_tmo", 32'(timeout), 32'd0);
      check("t5_busy",   32'(busy),    32'd1);
      drive_byte(8'h56);
      drive_byte(8'h70);
      $display("T5 DV on terminal count, frame AA 12 34 56 70");
      check("t5_valid", 32'(pkt_valid), 32'd1);
      check("t5_data",  32'(pkt_data),  32'h3456);
      check("t5_tmo_count", 32'(n_dut_to - v0), 32'd0);
      idle(2);

      // 5b. Reset mid-frame
      drive_byte(8'hAA);
      drive_byte(8'h12);
      drive_byte(8'h34);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      $display("T5b reset after AA 12 34");
      check("t5b_busy",  32'(busy),     32'd0);
      check("t5b_cmd",   32'(pkt_cmd),  32'd0);
      check("t5b_data",  32'(pkt_data), 32'd0);
      check("t5b_valid", 32'(pkt_valid | pkt_err | timeout), 32'd0);
      idle(3);
      rst_n = 1'b1;
      idle(2);

      // 6. Back-to-back frames
      v0 = n_dut_valid;
      send_frame(8'h01, 8'h02, 8'h03, 8'h00);
      check("t6_cmd1",  32'(pkt_cmd),  32'h01);
      check("t6_data1", 32'(pkt_data), 32'h0203);
      send_frame(8'h10, 8'h20, 8'h31, 8'h01);
      $display("T6 back-to-back frames");
      check("t6_valid", 32'(pkt_valid), 32'd1);
      check("t6_cmd2",  32'(pkt_cmd),   32'h10);
      check("t6_data2", 32'(pkt_data),  32'h2031);
      check("t6_count", 32'(n_dut_valid - v0), 32'd2);
      idle(2);

      // Randomized traffic
      for (int i = 0; i < 250; i++) begin
         kind = int'($urandom_range(0, 9));
         c  = 8'($urandom);
         hi = 8'($urandom);
         lo = 8'($urandom);
         ck = c ^ hi ^ lo;
         if (kind == 6 || kind == 7) ck = ck ^ (8'($urandom_range(1, 255)));
         $display("R%0d kind=%0d cmd=%h data=%h%h chk=%h", i, kind, c, hi, lo, ck);
         if (kind <= 7) begin
            idle(pick_gap()); drive_byte(8'hAA);
            idle(pick_gap()); drive_byte(c);
            idle(pick_gap()); drive_byte(hi);
            idle(pick_gap()); drive_byte(lo);
            idle(pick_gap()); drive_byte(ck);
         end else if (kind == 8) begin
            nb = int'($urandom_range(1, 4));
            for (int j = 0; j < nb; j++) begin
               b = 8'($urandom);
               if (b == 8'hAA) b = 8'h55;
               idle(int'($urandom_range(0, 3)));
               drive_byte(b);
            end
         end else begin
            nb = int'($urandom_range(1, 4));
            drive_byte(8'hAA);
            for (int j = 1; j < nb; j++) drive_byte(8'($urandom));
            idle(TO + 2);
         end
      end
      idle(TO + 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
